keypad_scanner: RTL and testbench

//   Scans a 4x4 matrix keypad: drives one column at a time, samples the rows,
//   and debounces across full scans. Presents one stable key as one-hot
//   row/col to the downstream keypad decoder; row/col are 0 when no key is held.

---
 rtl/keypad_scanner.sv | 130 +++++++++++++
 tb/tb_keypad_scanner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad one column at a time and debounces the result
//   over whole scans. It reports one stable key as a one-hot row/col pair.
//   Scans that see no key, or more than one key, report "no key". This also
//   rejects ghost keys.
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   row_in[3:0]  raw keypad rows (async, active-high)
//   col_drive    one-hot column drive
//   row, col     debounced one-hot key position, 0 = no key
//   key_press    1-cycle pulse when row/col take a new nonzero key
//   key_release  1-cycle pulse when row/col return to 0
module keypad_scanner #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_drive,
   output logic [3:0] row,
   output logic [3:0] col,
   output logic       key_press,
   output logic       key_release
);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
   localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE);

   logic [3:0]    s1, row_s;
   logic [1:0]    idx;
   logic [DW-1:0] dwell;
   logic [2:0]    hits;        // saturates at 2: only 0 / 1 / many matter
   logic [3:0]    acc_row, acc_col;
   logic [7:0]    cand;
   logic [CW-1:0] cnt;

   logic          samp, eval, upd;
   logic [2:0]    nbits, hits_nx;
   logic [3:0]    hits_sum;
   logic [3:0]    acc_row_nx, acc_col_nx;
   logic [7:0]    result, cand_nx;
   logic [CW-1:0] cnt_nx;

   // Sample at the end of the dwell so the row lines have settled and
   // passed through the synchroniser.
   assign samp      = (dwell == DWELL_MAX);
   assign eval      = samp && (idx == 2'd3);
   assign col_drive = 4'b0001 << idx;

   always_comb begin
      nbits    = 3'(row_s[0]) + 3'(row_s[1]) + 3'(row_s[2]) + 3'(row_s[3]);
      hits_sum = {1'b0, hits} + {1'b0, nbits};
      hits_nx  = (hits_sum >= 4'd2) ? 3'd2 : hits_sum[2:0];
      // Only the first single-bit sample in a clean scan is kept. If the
      // scan later sees more hits, the result is discarded anyway.
      if (hits == 3'd0 && nbits == 3'd1) begin
         acc_row_nx = row_s;
         acc_col_nx = col_drive;
      end else begin
         acc_row_nx = acc_row;
         acc_col_nx = acc_col;
      end
      result = (hits_nx == 3'd1) ? {acc_row_nx, acc_col_nx} : 8'h00;
      if (result == cand) begin
         cand_nx = cand;
         cnt_nx  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      end else begin
         cand_nx = result;
         cnt_nx  = CW'(1);
      end
   end

   // A candidate that has been stable long enough and differs from the
   // current output is published on the following edge.
   assign upd = (cnt == CNT_MAX) && (cand != {row, col});

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= '0;
         row_s <= '0;
      end else begin
         s1    <= row_in;
         row_s <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         dwell   <= '0;
         hits    <= '0;
         acc_row <= '0;
         acc_col <= '0;
         cand    <= '0;
         cnt     <= '0;
      end else if (samp) begin
         dwell <= '0;
         idx   <= idx + 2'd1;
         if (eval) begin
            hits    <= '0;
            acc_row <= '0;
            acc_col <= '0;
            cand    <= cand_nx;
            cnt     <= cnt_nx;
         end else begin
            hits    <= hits_nx;
            acc_row <= acc_row_nx;
            acc_col <= acc_col_nx;
         end
      end else begin
         dwell <= dwell + DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row         <= '0;
         col         <= '0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_press   <= upd && (cand != 8'h00);
         key_release <= upd && (cand == 8'h00);
         if (upd) {row, col} <= cand;
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row_in, col_drive, row, col;
   logic       key_press, key_release;

   // pressed[r][c] = key at row r / column c is held
   logic [3:0][3:0] pressed = '0;

   typedef struct {
      bit         rel;
      logic [3:0] r;
      logic [3:0] c;
   } ev_t;

   ev_t exp_q[$];
   ev_t e;
   int  errors = 0;
   int  checks = 0;
   int  ev_cnt = 0;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
      .clk(clk), .rst(rst), .row_in(row_in), .col_drive(col_drive),
      .row(row), .col(col), .key_press(key_press), .key_release(key_release)
   );

   always #5 clk = ~clk;

   always_comb
      for (int r = 0; r < 4; r++) row_in[r] = |(col_drive & pressed[r]);

   // Scoreboard: every pulse must match the next expected event.
   always @(negedge clk) begin
      if (!rst) begin
         if (key_press && key_release) begin
            checks++; errors++;
            $display("FAIL both_pulses: press=%b release=%b required not both", key_press, key_release);
         end
         if (key_press || key_release) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: press=%b release=%b row=%b col=%b required no pulse",
                        key_press, key_release, row, col);
            end else begin
               e = exp_q.pop_front();
               if (key_release !== e.rel || key_press !== !e.rel || row !== e.r || col !== e.c) begin
                  errors++;
                  $display("FAIL event: press=%b release=%b row=%b col=%b required release=%b row=%b col=%b",
                           key_press, key_release, row, col, e.rel, e.r, e.c);
               end
            end
            ev_cnt++;
         end
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
   endtask

   task automatic push(input bit rel, input logic [3:0] r, input logic [3:0] c);
      ev_t x;
      x.rel = rel; x.r = r; x.c = c;
      exp_q.push_back(x);
   endtask

   // Waits until ev_cnt reaches target; took = cycles spent, -1 on timeout.
   task automatic wait_ev(input int target, input int bound, output int took);
      took = -1;
      for (int i = 1; i <= bound; i++) begin
         tick();
         if (ev_cnt >= target) begin took = i; break; end
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_cd;
      do_reset();
      checks++;
      if (col_drive !== 4'b0001 || row !== 4'b0 || col !== 4'b0 || key_press !== 1'b0 || key_release !== 1'b0) begin
         errors++;
         $display("FAIL reset_vals: cd=%b row=%b col=%b kp=%b kr=%b required 0001/0/0/0/0",
                  col_drive, row, col, key_press, key_release);
      end
      for (int k = 0; k < 20; k++) begin
         exp_cd = 4'b0001 << ((k / 4) % 4);
         checks++;
         if (col_drive !== exp_cd) begin
            errors++;
            $display("FAIL rotate k=%0d: cd=%b required %b", k, col_drive, exp_cd);
         end
         tick();
      end
   endtask

   task automatic test_single_key();
      int took;
      push(1'b0, 4'b0001, 4'b0010);
      pressed[0] = 4'b0010;
      wait_ev(ev_cnt + 1, 67, took);
      checks++;
      if (took < 0) begin
         errors++;
         $display("FAIL press_latency: no key_press within 67 cycles, required one");
      end
      for (int k = 0; k < 80 - (took < 0 ? 67 : took); k++) begin
         tick();
         checks++;
         if (row !== 4'b0001 || col !== 4'b0010) begin
            errors++;
            $display("FAIL held_steady: row=%b col=%b required 0001/0010", row, col);
         end
      end
      push(1'b1, 4'b0, 4'b0);
      pressed = '0;
      wait_ev(ev_cnt + 1, 67, took);
      checks++;
      if (took < 0) begin
         errors++;
         $display("FAIL release_latency: no key_release within 67 cycles, required one");
      end
   endtask

   task automatic test_bounce();
      for (int k = 0; k < 280; k++) begin
         if (k < 200) pressed[1] = ((k / 20) % 2 == 0) ? 4'b0001 : 4'b0000;
         else         pressed = '0;
         tick();
         checks++;
         if (row !== 4'b0 || col !== 4'b0) begin
            errors++;
            $display("FAIL bounce k=%0d: row=%b col=%b required 0/0", k, row, col);
         end
      end
   endtask

   task automatic test_multi_key();
      int took;
      pressed[1] = 4'b0101;
      for (int k = 0; k < 160; k++) begin
         tick();
         checks++;
         if (row !== 4'b0 || col !== 4'b0) begin
            errors++;
            $display("FAIL multi_key k=%0d: row=%b col=%b required 0/0", k, row, col);
         end
      end
      push(1'b0, 4'b0010, 4'b0001);
      pressed[1] = 4'b0001;
      wait_ev(ev_cnt + 1, 67, took);
      checks++;
      if (took < 0) begin
         errors++;
         $display("FAIL multi_remaining: no key_press within 67 cycles, required r1/c0");
      end
      push(1'b1, 4'b0, 4'b0);
      pressed = '0;
      wait_ev(ev_cnt + 1, 67, took);
      checks++;
      if (took < 0) begin
         errors++;
         $display("FAIL multi_release: no key_release within 67 cycles, required one");
      end
   endtask

   task automatic test_back_to_back();
      int took;
      push(1'b0, 4'b0100, 4'b0010);
      pressed[2] = 4'b0010;
      wait_ev(ev_cnt + 1, 67, took);
      checks++;
      if (took < 0) begin
         errors++;
         $display("FAIL b2b_first: no key_press within 67 cycles, required r2/c1");
      end
      // Switch keys in the same cycle; the output must never pass through 0.
      push(1'b0, 4'b0010, 4'b0100);
      pressed = '0;
      pressed[1] = 4'b0100;
      wait_ev(ev_cnt + 1, 90, took);
      checks++;
      if (took < 0) begin
         errors++;
         $display("FAIL b2b_second: no key_press within 90 cycles, required r1/c2");
      end
      push(1'b1, 4'b0, 4'b0);
      pressed = '0;
      wait_ev(ev_cnt + 1, 67, took);
      checks++;
      if (took < 0) begin
         errors++;
         $display("FAIL b2b_release: no key_release within 67 cycles, required one");
      end
   endtask

   task automatic test_reset_mid_debounce();
      int took;
      do_reset();
      pressed[3] = 4'b1000;
      // Evaluations land at cycles 15 and 31, so at cycle 40 cnt is 2.
      for (int k = 0; k < 40; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (col_drive !== 4'b0001 || row !== 4'b0 || col !== 4'b0 || key_press !== 1'b0 || key_release !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_vals: cd=%b row=%b col=%b kp=%b kr=%b required 0001/0/0/0/0",
                  col_drive, row, col, key_press, key_release);
      end
      push(1'b0, 4'b1000, 4'b1000);
      for (int k = 1; k <= 47; k++) begin
         tick();
         checks++;
         if (row !== 4'b0 || col !== 4'b0) begin
            errors++;
            $display("FAIL fresh_debounce k=%0d: row=%b col=%b required 0/0", k, row, col);
         end
      end
      wait_ev(ev_cnt + 1, 20, took);
      checks++;
      if (took < 0) begin
         errors++;
         $display("FAIL reset_accept: no key_press by 67 cycles after reset, required r3/c3");
      end
      push(1'b1, 4'b0, 4'b0);
      pressed = '0;
      wait_ev(ev_cnt + 1, 67, took);
      checks++;
      if (took < 0) begin
         errors++;
         $display("FAIL reset_release: no key_release within 67 cycles, required one");
      end
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_bounce();
      test_multi_key();
      test_back_to_back();
      test_reset_mid_debounce();
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_events: %0d pending required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
